// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller in front of a word-wide data memory.
// Optional macro LSU_SUBWORD_EN enables byte/halfword accesses.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   req_valid/req_ready  core request handshake
//   req_we, req_size     store flag, size (00 B, 01 H, 10 W, 11 rsvd)
//   req_unsigned         load zero-extends when set
//   req_addr, req_wdata  byte address, right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata, resp_err load result / access rejected
//   mem_en, mem_addr     memory write enable, word-aligned address
//   mem_in, mem_out      memory write data, async read data
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        err;
    logic [31:0] load_val;
    logic [31:0] store_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ACCESS) begin
                err_q   <= err;
                rdata_q <= (err || we_q) ? 32'h0 : load_val;
            end
        end
    end

    // Access legality check on the latched request.
    always_comb begin
        err = (addr_q[31:14] != 18'h0);
`ifdef LSU_SUBWORD_EN
        unique case (size_q)
            2'b00: ;
            2'b01: if (addr_q[0]) err = 1'b1;
            2'b10: if (addr_q[1:0] != 2'b00) err = 1'b1;
            default: err = 1'b1;
        endcase
`else
        if (size_q != 2'b10 || addr_q[1:0] != 2'b00)
            err = 1'b1;
`endif
    end

`ifdef LSU_SUBWORD_EN
    logic [31:0] byte_sh;
    logic [15:0] half_lane;

    assign byte_sh   = mem_out >> {addr_q[1:0], 3'b000};
    assign half_lane = addr_q[1] ? mem_out[31:16] : mem_out[15:0];

    always_comb begin
        unique case (size_q)
            2'b00: load_val = uns_q ? {24'h0, byte_sh[7:0]}
                                    : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'b01: load_val = uns_q ? {16'h0, half_lane}
                                    : {{16{half_lane[15]}}, half_lane};
            default: load_val = mem_out;
        endcase
    end

    // Sub-word stores merge into the current word read combinationally.
    always_comb begin
        store_val = mem_out;
        unique case (size_q)
            2'b00: begin
                unique case (addr_q[1:0])
                    2'b00: store_val[7:0]   = wdata_q[7:0];
                    2'b01: store_val[15:8]  = wdata_q[7:0];
                    2'b10: store_val[23:16] = wdata_q[7:0];
                    default: store_val[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) store_val[31:16] = wdata_q[15:0];
                else           store_val[15:0]  = wdata_q[15:0];
            end
            default: store_val = wdata_q;
        endcase
    end
`else
    logic unused_sub;
    assign unused_sub = uns_q;
    assign load_val   = mem_out;
    assign store_val  = wdata_q;
`endif

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = 32'h0;
        mem_in     = 32'h0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ACCESS;
            end
            ACCESS: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (we_q && !err) begin
                    mem_en = 1'b1;
                    mem_in = store_val;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl.
// Models a 16 KB word memory with asynchronous read.
module tb_lsu_ctrl;

`ifdef LSU_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic [31:0] mem_out;

    logic [31:0] mem [0:4095];
    int          wr_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_in       (mem_in),
        .mem_out      (mem_out)
    );

    assign mem_out = mem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (mem_en) begin
            mem[mem_addr[13:2]] <= mem_in;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag,
                           input logic we,
                           input logic [1:0] size,
                           input logic uns,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input logic [31:0] exp_rdata,
                           input logic exp_err,
                           input int exp_wr);
        int n;
        int wr0;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_rv_early"}, {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        check({tag, "_rv"}, {31'h0, resp_valid}, 32'h1);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        check({tag, "_wr"}, wr_cnt - wr0, exp_wr);
    endtask

    int acc_q[$];
    int rsp_n;
    int cyc;
    bit mon = 1'b0;

    always @(negedge clk) begin
        if (mon) begin
            cyc++;
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (resp_valid) rsp_n++;
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        #2;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rv", {31'h0, resp_valid}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'h0, resp_err}, 32'h0);
        check("rst_men", {31'h0, mem_en}, 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_min", mem_in, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req("sw", 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1);
        check("sw_mem", mem[32'h40], 32'hDEADBEEF);
        run_req("lw", 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);

        mem[32'h80] = 32'h11223344;
        run_req("sb", 1, 2'b00, 0, 32'h202, 32'h555555AA,
                32'h0, !SUB, SUB ? 1 : 0);
        check("sb_mem", mem[32'h80], SUB ? 32'h11AA3344 : 32'h11223344);
        run_req("lb_s", 0, 2'b00, 0, 32'h202, 32'h0,
                SUB ? 32'hFFFFFFAA : 32'h0, !SUB, 0);
        run_req("lb_u", 0, 2'b00, 1, 32'h202, 32'h0,
                SUB ? 32'h000000AA : 32'h0, !SUB, 0);

        mem[32'h80] = 32'h80017FFF;
        run_req("lh_s", 0, 2'b01, 0, 32'h202, 32'h0,
                SUB ? 32'hFFFF8001 : 32'h0, !SUB, 0);
        run_req("lh_u", 0, 2'b01, 1, 32'h200, 32'h0,
                SUB ? 32'h00007FFF : 32'h0, !SUB, 0);

        run_req("e_sw102", 1, 2'b10, 0, 32'h102, 32'h12345678, 32'h0, 1, 0);
        check("e_sw102_mem", mem[32'h40], 32'hDEADBEEF);
        run_req("e_h201", 0, 2'b01, 0, 32'h201, 32'h0, 32'h0, 1, 0);
        run_req("e_sz11", 0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 1, 0);
        run_req("e_lw4000", 0, 2'b10, 0, 32'h4000, 32'h0, 32'h0, 1, 0);
        run_req("e_sw4000", 1, 2'b10, 0, 32'h4000, 32'h1, 32'h0, 1, 0);
        check("e_sw4000_mem", mem[0], 32'h0);

        mem[32'hC0] = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h300;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rs_men_pre", {31'h0, mem_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_men", {31'h0, mem_en}, 32'h0);
        check("rs_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("rs_mem", mem[32'hC0], 32'h12345678);
        check("rs_rv", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_rv2", {31'h0, resp_valid}, 32'h0);
        check("rs_ready2", {31'h0, req_ready}, 32'h1);
        run_req("rs_lw", 0, 2'b10, 0, 32'h300, 32'h0, 32'h12345678, 0, 0);

        @(posedge clk);
        #1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h100;
        req_valid = 1'b1;
        cyc   = 0;
        rsp_n = 0;
        mon   = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        mon       = 1'b0;
        req_valid = 1'b0;
        check("hs_acc_n", acc_q.size(), 4);
        for (int i = 1; i < acc_q.size(); i++)
            check($sformatf("hs_gap%0d", i), acc_q[i] - acc_q[i-1], 3);
        check("hs_rsp_n", rsp_n, 4);
        check("hs_rdata", resp_rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting directly upstream of the word-wide data memory. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake. It translates them into word-aligned data-memory accesses, performing read-modify-write merges for sub-word stores and lane-select plus sign/zero extension for loads. It flags misaligned, reserved-size and out-of-range accesses instead of touching memory.

## Interface
- No parameters; the memory window is fixed at 16 KB (word index = addr[13:2]).
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result; 0 for stores and errors
- resp_err  output  1  valid with resp_valid; access rejected
- mem_en  output  1  data-memory write enable
- mem_addr  output  32  word-aligned address, addr[1:0] = 00
- mem_in  output  32  data-memory write data
- mem_out  input  32  data-memory read data (asynchronous read)

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/size/unsigned/addr/wdata and go to ACCESS.
- ACCESS:
  - req_ready = 0.
  - mem_addr = {latched addr[31:2], 2'b00}.
  - Error if any of: size = 11; half with addr[0] = 1; word with addr[1:0] ≠ 00; addr[31:14] ≠ 0.
  - Load: select the lane from mem_out (little-endian, byte 0 = bits 7:0), then extend per req_unsigned into a result register.
  - Word store: mem_en = 1, mem_in = wdata.
  - Sub-word store: mem_in = mem_out with the addressed byte or halfword lane replaced by wdata[7:0] or wdata[15:0]; mem_en = 1. This is a single-cycle RMW and is legal because the memory read is combinational.
  - On error: mem_en = 0 and the result register is 0.
  - Always go to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, together with resp_rdata and resp_err.
  - req_ready = 0; go to IDLE.
- mem_en is asserted only in ACCESS, for a non-error store. It is never asserted in IDLE or RESP.
- Requests presented while req_ready = 0 are ignored. The core must hold them until accepted.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_en 0, mem_addr 0, mem_in 0.
- Latency:
  - Request accepted at edge N.
  - ACCESS occupies cycle N→N+1; the memory write commits at edge N+1.
  - resp_valid is high during cycle N+1→N+2.
- Throughput: one request per 3 cycles. req_ready returns high the cycle after RESP.
- A load that follows a store in the next request observes the stored data, because the write committed two cycles earlier.
- Reset asserted mid-operation:
  - Return immediately to IDLE and drop the response.
  - If reset lands in ACCESS, mem_en deasserts asynchronously and no write commits.
- Outputs resp_rdata and resp_err are registered. mem_en, mem_addr and mem_in are decoded from registered state and latched fields only, never from live req_* inputs.

## Configuration
- LSU_SUBWORD_EN defined: byte and halfword accesses behave as above.
- LSU_SUBWORD_EN undefined:
  - req_size 00 and 01 are treated as reserved and flagged resp_err = 1 with no memory access.
  - The RMW merge and lane-extension logic are omitted.
  - Word behaviour and timing are unchanged.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x0000_0100, then load word from 0x100 → mem_en is pulsed once, resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid two cycles after each accept.
- Byte RMW: with word 0x11223344 at 0x200, store byte 0xAA at 0x202 → memory becomes 0x11AA3344. A signed byte load from 0x202 returns 0xFFFFFFAA; an unsigned one returns 0x000000AA.
- Halfword: signed load from 0x202 of word 0x80017FFF → 0xFFFF8001. An unsigned halfword load from 0x200 → 0x00007FFF.
- Errors (no memory write, resp_err = 1, resp_rdata = 0):
  - word store at 0x102;
  - halfword at 0x201;
  - size 11;
  - address 0x0000_4000.
- Reset during ACCESS of a store to 0x300: mem_en falls immediately, the word at 0x300 is unchanged, no resp_valid, req_ready = 1 after release.
- Handshake: hold req_valid high continuously with back-to-back requests → accepts occur exactly every 3 cycles, with one resp_valid pulse per accept.
